data_mem_port: RTL
==================

Name: data_mem_port

Overview:
- Data-side memory access controller in the MEM stage.
- Converts MEM-stage load/store flags into a request/response transaction on the external data bus, which has variable latency.
- Holds the pipeline with a stall request while a transaction is outstanding.
- Presents the returned load word on ram_read_data, which the MEM/WB pipeline register captures.
- It is the producer and responder side of the RAM read-data path that the MEM/WB register consumes.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width.
- SEL_WIDTH, 4, byte-enable width (DATA_WIDTH/8).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush (exception/eret); kills the current MEM-stage access.
- mem_read_flag  in  1  MEM-stage instruction is a load.
- mem_write_flag  in  1  MEM-stage instruction is a store.
- mem_sel  in  SEL_WIDTH  byte lanes of the access.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_write_data  in  DATA_WIDTH  lane-aligned store data.
- stall_request  out  1  holds PC..MEM stages while high.
- bus_req  out  1  request valid.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_WIDTH  word-aligned address, {mem_addr[31:2], 2'b00}.
- bus_be  out  SEL_WIDTH  byte enables.
- bus_wdata  out  DATA_WIDTH  write data.
- bus_addr_ok  in  1  request accepted this cycle.
- bus_data_ok  in  1  response this cycle; read data valid, or write complete.
- bus_rdata  in  DATA_WIDTH  read data.
- ram_read_data  out  DATA_WIDTH  last completed load word; sampled by MEM/WB.

Behaviour:
- access = (mem_read_flag | mem_write_flag) & ~flush.
- States: IDLE, REQ, WAIT, DONE.
- Reset (rst=0, async):
  - State = IDLE; all request registers, discard flag and ram_read_data = 0.
  - bus_req = 0, stall_request = 0.
- IDLE:
  - If access: latch bus_we = mem_write_flag, bus_addr, bus_be = mem_sel, bus_wdata; go to REQ.
  - stall_request is combinationally 1 in IDLE when access = 1, so the instruction holds in MEM.
- REQ:
  - bus_req = 1. Request fields are stable and bus_req cannot be dropped until bus_addr_ok.
  - On bus_addr_ok & bus_data_ok in the same cycle: complete (see completion below).
  - On bus_addr_ok alone: go to WAIT.
- WAIT:
  - bus_req = 0.
  - On bus_data_ok: complete.
- Completion:
  - If the access is a load and discard = 0: ram_read_data <= bus_rdata.
  - If discard = 0: go to DONE; if discard = 1: go to IDLE.
- DONE:
  - stall_request = 0 for exactly one cycle, so MEM/WB captures ram_read_data and the pipeline advances.
  - Request inputs are ignored in this cycle (they still show the finished instruction).
  - Go to IDLE.
- stall_request = (state==REQ) | (state==WAIT) | (state==IDLE & access).
- Latency: zero-wait bus (addr_ok and data_ok in the first REQ cycle) gives 2 stall cycles (IDLE, REQ), then DONE. Each extra bus wait cycle adds one stall cycle.
- Flush while in REQ or WAIT:
  - Set discard = 1; the transaction still runs to completion (no abort on the bus).
  - stall_request stays 1 until completion; ram_read_data is not updated.
  - Return to IDLE directly; discard is cleared on leaving to IDLE.
- Flush in IDLE: no request issued, no stall.
- Flush in DONE: no effect (the result is already committed).
- ram_read_data:
  - Holds its value across stores, stalls and idle cycles.
  - Updates only on a non-discarded load completion.
- Store completions never modify ram_read_data.
- bus_data_ok in IDLE or DONE: ignored. This is a protocol violation; the bench flags it as an error.
- Reset mid-transaction returns to IDLE immediately. The bus side must be reset together with this block.

Test Plan:
- Zero-wait load: mem_read_flag=1, addr 0x0000_1006, sel 4'b0100; bus gives addr_ok=data_ok=1 in the first REQ cycle with rdata 0xA1B2C3D4 -> bus_addr 0x0000_1004, bus_be 4'b0100, bus_we 0; stall high 2 cycles; ram_read_data = 0xA1B2C3D4 in DONE; stall low in DONE.
- Slow store: mem_write_flag=1, addr 0x10, wdata 0x0000_00FF, sel 4'b0001; addr_ok after 3 cycles, data_ok 2 cycles later -> bus_req held 4 cycles with fields stable; bus_req=0 in WAIT; stall high throughout; ram_read_data unchanged.
- Flush during WAIT of a load (rdata 0xDEADBEEF) -> stall stays high until data_ok; ram_read_data keeps its prior value 0xA1B2C3D4; next state IDLE; no DONE cycle.
- Flush coincident with a new load in IDLE -> bus_req never asserted; stall_request 0.
- Back-to-back loads at 0x20 (rdata 0x11111111) and 0x24 (rdata 0x22222222) -> each access gets its own IDLE->REQ->DONE; inputs in DONE are not re-issued; ram_read_data sequence 0x11111111 then 0x22222222.
- rst=0 asserted in WAIT -> outputs are 0 asynchronously, before the next clock edge; after release, state is IDLE with no request.

Source files
------------

// File: rtl/data_mem_port_if.sv
// Data-side bus between the MEM-stage access controller and the memory system.
// Request fields are driven by the master; the two acknowledge strobes and the read data come back from the slave.
interface data_mem_port_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [SEL_WIDTH-1:0]  bus_be;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_addr_ok,
    input  bus_data_ok,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_addr_ok,
    output bus_data_ok,
    output bus_rdata
  );
endinterface

// File: rtl/data_mem_port.sv
// MEM-stage data access controller: turns load/store flags into one variable-latency bus
// transaction, stalls the pipeline while it is outstanding and holds the last loaded word.
module data_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  mem_read_flag,
  input  logic                  mem_write_flag,
  input  logic [SEL_WIDTH-1:0]  mem_sel,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  stall_request,
  output logic [DATA_WIDTH-1:0] ram_read_data,
  data_mem_port_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SEL_WIDTH-1:0]  be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  discard_q, discard_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic access;
  logic complete;
  logic discard_now;
  logic unused_addr_bits;

  // Qualified with rst so stall_request drops the moment reset is asserted,
  // even while the pipeline still presents a load or store.
  assign access = rst & (mem_read_flag | mem_write_flag) & ~flush;

  assign unused_addr_bits = ^mem_addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      discard_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      discard_q <= discard_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    discard_d   = discard_q;
    rdata_d     = rdata_q;
    complete    = 1'b0;
    discard_now = discard_q | flush;

    case (state_q)
      IDLE: begin
        if (access) begin
          we_d      = mem_write_flag;
          addr_d    = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
          be_d      = mem_sel;
          wdata_d   = mem_write_data;
          discard_d = 1'b0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          discard_d = 1'b1;
        end
        if (bus.bus_addr_ok) begin
          if (bus.bus_data_ok) begin
            complete = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          discard_d = 1'b1;
        end
        if (bus.bus_data_ok) begin
          complete = 1'b1;
        end
      end
      DONE: begin
        // The finished instruction is still on the inputs here, so never re-issue it.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A killed access still finishes on the bus, but leaves no trace and skips DONE.
    if (complete) begin
      if (!discard_now && !we_q) begin
        rdata_d = bus.bus_rdata;
      end
      state_d   = discard_now ? IDLE : DONE;
      discard_d = 1'b0;
    end
  end

  assign bus.bus_req   = (state_q == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

  assign stall_request = (state_q == REQ) | (state_q == WAIT) | ((state_q == IDLE) & access);
  assign ram_read_data = rdata_q;

endmodule
